// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive path.
//   rx_ctrl_state_t : receive frame controller states
//   HDLC_FLAG       : flag octet 0x7E
//   RX_BUF_DEPTH    : default Rx buffer depth in bytes
//   RX_MIN_BYTES    : default minimum accepted frame length (FCS included)
package hdlc_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, FLAGGED, RECV, HOLD} rx_ctrl_state_t;
  localparam logic [7:0] HDLC_FLAG    = 8'h7E;
  localparam int         RX_BUF_DEPTH = 128;
  localparam int         RX_MIN_BYTES = 3;
endpackage

// File: rtl/hdlc_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   Clk, Rst : clock, async active-high reset
//   Clr      : clear to 0 (wins over Inc)
//   Inc      : increment, ignored once Count reaches LIMIT
//   Count    : current value
//   AtLimit  : Count == LIMIT
module hdlc_sat_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 128
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count,
  output logic             AtLimit
);
  assign AtLimit = (Count == CNT_W'(LIMIT));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                  Count <= '0;
    else if (Clr)             Count <= '0;
    else if (Inc && !AtLimit) Count <= Count + CNT_W'(1);
  end
endmodule

// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller. Turns flag/abort/byte events into Rx
// buffer writes, tracks frame length, overflow and short frames, and holds a
// completed frame until software reads it out or drops it.
//   Clk, Rst        : clock, async active-high reset
//   Rx_Enable       : receiver enable level
//   Rx_FlagDetect   : flag seen pulse
//   Rx_AbortDetect  : abort (7+ ones) pulse
//   Rx_NewByte      : Rx_Data valid pulse
//   Rx_Data         : destuffed byte
//   Rx_BufRead      : software consumed byte at Rx_RdAddr
//   Rx_Drop         : software discards held frame
//   Rx_ValidFrame   : frame reception in progress
//   Rx_WrBuff/Rx_WrAddr/Rx_WrData : buffer write port
//   Rx_RdAddr       : buffer read address
//   Rx_AbortSignal  : aborted-frame pulse
//   Rx_Overflow     : held frame exceeded BUF_DEPTH (sticky)
//   Rx_Ready        : a complete frame is held
//   Rx_FrameSize    : byte count of the held frame
//   Rx_FrameError   : short-frame pulse
module hdlc_rx_frame_ctrl
  import hdlc_pkg::*;
#(
  parameter int BUF_DEPTH = RX_BUF_DEPTH,
  parameter int CNT_W     = 8,
  parameter int MIN_BYTES = RX_MIN_BYTES
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx_Enable,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_NewByte,
  input  logic [7:0]       Rx_Data,
  input  logic             Rx_BufRead,
  input  logic             Rx_Drop,
  output logic             Rx_ValidFrame,
  output logic             Rx_WrBuff,
  output logic [CNT_W-1:0] Rx_WrAddr,
  output logic [7:0]       Rx_WrData,
  output logic [CNT_W-1:0] Rx_RdAddr,
  output logic             Rx_AbortSignal,
  output logic             Rx_Overflow,
  output logic             Rx_Ready,
  output logic [CNT_W-1:0] Rx_FrameSize,
  output logic             Rx_FrameError
);
  rx_ctrl_state_t state;

  logic [CNT_W-1:0] wrCnt;
  logic             wrFull, rdAtLimit;
  logic             rxOff, abortEv, flagEv, byteEv;
  logic             closeOk, closeShort, release_, lastRead;
  logic             wrInc, wrClr, rdInc, rdClr;

  // Event decode. Disable beats everything while receiving; then
  // abort > flag > byte, so a losing byte is never written.
  always_comb begin
    rxOff      = !Rx_Enable && (state inside {HUNT, FLAGGED, RECV});
    abortEv    = !rxOff && Rx_AbortDetect && (state inside {HUNT, FLAGGED, RECV});
    flagEv     = !rxOff && !Rx_AbortDetect && Rx_FlagDetect &&
                 (state inside {HUNT, FLAGGED, RECV});
    byteEv     = !rxOff && !Rx_AbortDetect && !Rx_FlagDetect && Rx_NewByte &&
                 (state inside {FLAGGED, RECV});
    closeOk    = flagEv && (state == RECV) && (wrCnt >= CNT_W'(MIN_BYTES));
    closeShort = flagEv && (state == RECV) && (wrCnt <  CNT_W'(MIN_BYTES));
    lastRead   = (Rx_RdAddr + CNT_W'(1)) == Rx_FrameSize;
    release_   = (state == HOLD) && (Rx_Drop || (Rx_BufRead && lastRead));
    wrInc      = byteEv && !wrFull;
    wrClr      = rxOff || (abortEv && state == RECV) || closeShort || release_;
    rdInc      = (state == HOLD) && Rx_BufRead && !release_ && !rdAtLimit;
    rdClr      = release_;
  end

  hdlc_sat_counter #(.CNT_W(CNT_W), .LIMIT(BUF_DEPTH)) uWrCnt (
    .Clk(Clk), .Rst(Rst), .Clr(wrClr), .Inc(wrInc),
    .Count(wrCnt), .AtLimit(wrFull)
  );

  hdlc_sat_counter #(.CNT_W(CNT_W), .LIMIT(BUF_DEPTH-1)) uRdCnt (
    .Clk(Clk), .Rst(Rst), .Clr(rdClr), .Inc(rdInc),
    .Count(Rx_RdAddr), .AtLimit(rdAtLimit)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state          <= IDLE;
      Rx_ValidFrame  <= 1'b0;
      Rx_WrBuff      <= 1'b0;
      Rx_WrAddr      <= '0;
      Rx_WrData      <= '0;
      Rx_AbortSignal <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_Ready       <= 1'b0;
      Rx_FrameSize   <= '0;
      Rx_FrameError  <= 1'b0;
    end else begin
      Rx_WrBuff      <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
      if (wrInc) begin
        Rx_WrBuff <= 1'b1;
        Rx_WrAddr <= wrCnt;
        Rx_WrData <= Rx_Data;
      end
      if (rxOff) begin
        // partial frame silently discarded
        state         <= IDLE;
        Rx_ValidFrame <= 1'b0;
        Rx_Overflow   <= 1'b0;
      end else begin
        case (state)
          IDLE:    if (Rx_Enable) state <= HUNT;
          HUNT:    if (flagEv) state <= FLAGGED;
          FLAGGED: begin
            if (abortEv) state <= HUNT;
            else if (byteEv) begin
              state         <= RECV;
              Rx_ValidFrame <= 1'b1;
            end
          end
          RECV: begin
            if (abortEv) begin
              state          <= HUNT;
              Rx_ValidFrame  <= 1'b0;
              Rx_AbortSignal <= 1'b1;
              Rx_Overflow    <= 1'b0;
            end else if (closeOk) begin
              state         <= HOLD;
              Rx_ValidFrame <= 1'b0;
              Rx_Ready      <= 1'b1;
              Rx_FrameSize  <= wrCnt;
            end else if (closeShort) begin
              // closing flag doubles as the next opening flag
              state         <= FLAGGED;
              Rx_ValidFrame <= 1'b0;
              Rx_FrameError <= 1'b1;
              Rx_Overflow   <= 1'b0;
            end else if (byteEv && wrFull) begin
              Rx_Overflow <= 1'b1;
            end
          end
          HOLD: begin
            if (release_) begin
              state        <= Rx_Enable ? HUNT : IDLE;
              Rx_Ready     <= 1'b0;
              Rx_Overflow  <= 1'b0;
              Rx_FrameSize <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/hdlc_rx_frame_ctrl.md
Name: hdlc_rx_frame_ctrl

Overview:
Receive-side frame controller for the HDLC core. It consumes flag, abort and byte-ready events from the Rx flag/abort detector and destuffing byte assembler, and writes frame bytes into the Rx buffer. It tracks frame size, overflow and short frames, and holds a completed frame until software reads it or drops it. It is the block that drives Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal and Rx_Overflow.

Parameters:
BUF_DEPTH, 128, Rx buffer depth in bytes; maximum number of stored bytes per frame (FCS included).
CNT_W, 8, width of the byte/address counters; must satisfy 2**CNT_W > BUF_DEPTH.
MIN_BYTES, 3, minimum bytes between flags (FCS included) for a frame to be accepted.

Ports:
Clk  input  1  system clock.
Rst  input  1  asynchronous reset, active-high.
Rx_Enable  input  1  receiver enable (level).
Rx_FlagDetect  input  1  one-cycle pulse: flag 0x7E detected.
Rx_AbortDetect  input  1  one-cycle pulse: seven or more consecutive ones detected.
Rx_NewByte  input  1  one-cycle pulse: Rx_Data holds a new destuffed byte.
Rx_Data  input  8  byte from the assembler, valid with Rx_NewByte.
Rx_BufRead  input  1  one-cycle pulse: software consumed the byte at Rx_RdAddr.
Rx_Drop  input  1  one-cycle pulse: software discards the held frame.
Rx_ValidFrame  output  1  frame reception in progress.
Rx_WrBuff  output  1  buffer write strobe.
Rx_WrAddr  output  CNT_W  buffer write address.
Rx_WrData  output  8  buffer write data.
Rx_RdAddr  output  CNT_W  buffer read address.
Rx_AbortSignal  output  1  one-cycle pulse: frame aborted.
Rx_Overflow  output  1  sticky: held frame exceeded BUF_DEPTH.
Rx_Ready  output  1  a complete frame is held in the buffer.
Rx_FrameSize  output  CNT_W  byte count of the held frame.
Rx_FrameError  output  1  one-cycle pulse: short frame discarded.

Behaviour:
- All outputs are registered. Async reset sets every output and counter to 0 and the state to IDLE.
- States: IDLE, HUNT, FLAGGED, RECV, HOLD.
- IDLE: wait for Rx_Enable=1, then go to HUNT.
- HUNT: ignore bytes. Rx_FlagDetect moves to FLAGGED.
- FLAGGED: Rx_FlagDetect stays in FLAGGED (shared/back-to-back flags). Rx_NewByte moves to RECV and writes the byte.
- RECV:
  - Rx_ValidFrame=1.
  - A byte written in cycle n appears as Rx_WrBuff=1 in cycle n+1, with Rx_WrAddr = count before increment and Rx_WrData = Rx_Data.
  - When count == BUF_DEPTH and another byte arrives: no write, Rx_Overflow set next cycle, count saturates, reception continues.
- Closing flag in RECV:
  - count >= MIN_BYTES: go to HOLD. Rx_FrameSize = count, Rx_Ready=1, Rx_ValidFrame=0, all in the next cycle.
  - count < MIN_BYTES: Rx_FrameError pulses. Go to FLAGGED (the closing flag opens the next frame). Count and Rx_Overflow clear.
- Rx_AbortDetect while Rx_ValidFrame=1: Rx_AbortSignal pulses in the next cycle (exactly one cycle). Rx_ValidFrame drops in that same cycle. Count clears, go to HUNT.
- Rx_AbortDetect in FLAGGED or HUNT: go to HUNT, no pulse.
- HOLD:
  - New flags, bytes and aborts are ignored.
  - Each Rx_BufRead increments Rx_RdAddr.
  - A read at Rx_RdAddr == Rx_FrameSize-1, or Rx_Drop, releases the frame. Next cycle: Rx_Ready=0, Rx_Overflow=0, Rx_FrameSize=0, Rx_RdAddr=0, state HUNT if enabled, else IDLE.
- Rx_Enable=0 in HUNT, FLAGGED or RECV: go to IDLE next cycle. A partial frame is discarded with no Rx_AbortSignal. HOLD is unaffected.
- Simultaneous events, by priority: abort > flag > byte. The losing byte is not written.
- Rx_BufRead outside HOLD is ignored.

Decomposition:
- Package hdlc_pkg holds:
  - state enum rx_ctrl_state_t (IDLE, HUNT, FLAGGED, RECV, HOLD);
  - constant HDLC_FLAG = 8'h7E;
  - default constants RX_BUF_DEPTH and RX_MIN_BYTES.
- One sub-module, hdlc_sat_counter: CNT_W-bit counter with clear, increment and saturate-at-limit flag. Instantiated twice, as the write count and Rx_RdAddr.

Test Plan:
- Flag, bytes 0xA1 0xB2 0xC3 0xD4, flag -> Rx_WrBuff at addresses 0..3 with matching data, each one cycle after Rx_NewByte; then Rx_Ready=1, Rx_FrameSize=4.
- Frame of 3 bytes, then Rx_AbortDetect mid-frame -> Rx_AbortSignal high exactly one cycle, Rx_ValidFrame=0, Rx_Ready stays 0; a following flag plus 4 bytes plus flag is received normally.
- 130 bytes between flags with BUF_DEPTH=128 -> exactly 128 writes (addresses 0..127), Rx_Overflow=1, Rx_FrameSize=128; Rx_Drop clears Ready and Overflow.
- Flag, 2 bytes, flag, 3 bytes, flag -> Rx_FrameError pulse once, then Rx_Ready with Rx_FrameSize=3 and writes starting at address 0.
- Held frame of 5 bytes read with 5 Rx_BufRead pulses -> Rx_RdAddr 0..4, then Rx_Ready=0; bytes arriving during HOLD are never written.
- Rst asserted mid-RECV -> all outputs 0 immediately, without waiting for a clock edge; Rx_Enable=0 mid-frame -> IDLE with no Rx_AbortSignal.
